// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer
//   Issue stage in front of a 16-bit single-operand combinational ALU.
//   Commands {load, opcode, data} are buffered in a DEPTH-entry FIFO. The
//   sequencer pops one command at a time, drives the ALU from the accumulator,
//   writes the ALU result (or the load value) back into the accumulator, and
//   presents that value on a valid/ready output port.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
//   valid && ready. Once out_valid is raised, it stays high and out_data stays
//   constant until the transfer completes. in_ready depends only on the
//   registered FIFO occupancy. It never depends on in_valid or on a pop
//   happening in the same cycle.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  command handshake; in_load, in_opcode, in_data payload
//   alu_a, alu_opcode  ALU operand (always acc) and current/last opcode
//   alu_result         combinational ALU result, same cycle
//   out_valid/out_ready/out_data  result handshake
//   acc                current accumulator
//   busy               FSM not idle or FIFO non-empty
//   fifo_count         FIFO occupancy
//   fsm_state          FSM state for observation (0 IDLE, 1 EXEC, 2 WAIT_OUT)
module alu_acc_sequencer #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_load,
  input  logic [OPC_W-1:0]           in_opcode,
  input  logic [DATA_W-1:0]          in_data,
  output logic [DATA_W-1:0]          alu_a,
  output logic [OPC_W-1:0]           alu_opcode,
  input  logic [DATA_W-1:0]          alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [DATA_W-1:0]          acc,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [1:0]                 fsm_state
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + OPC_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  assign in_ready = (fifo_count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  // Pops happen only from IDLE, so a command never overlaps a pending result.
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign head     = mem[rd_ptr];

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_load, in_opcode, in_data};
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  logic              cmd_load;
  logic [DATA_W-1:0] cmd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      alu_opcode <= '0;
      cmd_load   <= 1'b0;
      cmd_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {cmd_load, alu_opcode, cmd_data} <= head;
            state <= EXEC;
          end
        end
        EXEC: begin
          // alu_result reflects alu_a = acc and alu_opcode during this cycle.
          acc       <= cmd_load ? cmd_data : alu_result;
          out_data  <= cmd_load ? cmd_data : alu_result;
          out_valid <= 1'b1;
          state     <= WAIT_OUT;
        end
        WAIT_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a     = acc;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
module tb_alu_acc_sequencer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_load;
  logic [2:0]  in_opcode;
  logic [15:0] in_data;
  logic [15:0] alu_a, alu_result, out_data, acc;
  logic [2:0]  alu_opcode;
  logic        out_valid, out_ready, busy;
  logic [2:0]  fifo_count;
  logic [1:0]  fsm_state;

  alu_acc_sequencer #(.DATA_W(16), .OPC_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_opcode(in_opcode), .in_data(in_data),
    .alu_a(alu_a), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .acc(acc), .busy(busy), .fifo_count(fifo_count), .fsm_state(fsm_state)
  );

  // Single-operand ALU used by this environment.
  function automatic logic [15:0] alu_fn(logic [2:0] op, logic [15:0] a);
    case (op)
      3'd0:    return a + 16'd1;
      3'd1:    return a - 16'd1;
      3'd2:    return ~a;
      3'd3:    return 16'd0 - a;
      3'd4:    return a << 1;
      3'd5:    return a >> 1;
      3'd6:    return a;
      default: return 16'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_a);

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: expected out_data pushed on command acceptance, popped on
  // each output transfer. Sampled on the falling edge, where the values that
  // decide the next rising edge are stable.
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic [15:0] model_acc = 16'd0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = 16'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("out_valid_hold", {31'd0, out_valid}, 32'd1);
        check("out_data_hold", {16'd0, out_data}, {16'd0, prev_data});
      end
      if (in_valid && in_ready) begin
        model_acc = in_load ? in_data : alu_fn(in_opcode, model_acc);
        exp_q.push_back(model_acc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {16'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          check("sb_out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    model_acc = 16'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic push_cmd(input logic ld, input logic [2:0] op, input logic [15:0] d);
    logic ok;
    in_valid  = 1'b1;
    in_load   = ld;
    in_opcode = op;
    in_data   = d;
    for (int i = 0; i < 50; i++) begin
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", {31'd0, (busy || out_valid)}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        load;
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] exp_acc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    int accepted;
    logic ok;

    vecs[0] = '{1'b1, 3'd0, 16'h1234, 16'h1234};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 16'h1235};
    vecs[2] = '{1'b0, 3'd2, 16'h0000, 16'hEDCA};
    vecs[3] = '{1'b0, 3'd5, 16'h0000, 16'h76E5};
    vecs[4] = '{1'b1, 3'd0, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 3'd0, 16'hABCD, 16'hABCD};
    vecs[7] = '{1'b0, 3'd7, 16'h0000, 16'h0000};

    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_opcode = 3'd0;
    in_data = 16'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state (rst_n still low here).
    check("rst_acc", {16'd0, acc}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Latency: enqueue at edge N, out_valid high after edge N+2.
    push_cmd(1'b1, 3'd0, 16'h1234);
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency_cycles", k, 32'd2);
    wait_idle();

    // Table-driven command sequence.
    for (int i = 0; i < 8; i++) begin
      push_cmd(vecs[i].load, vecs[i].op, vecs[i].data);
      wait_idle();
      check($sformatf("vec%0d_acc", i), {16'd0, acc}, {16'd0, vecs[i].exp_acc});
      check($sformatf("vec%0d_out_data", i), {16'd0, out_data}, {16'd0, vecs[i].exp_acc});
    end

    // alu_a during EXEC after a load of 0xABCD.
    push_cmd(1'b1, 3'd0, 16'hABCD);
    wait_idle();
    push_cmd(1'b0, 3'd7, 16'h0000);
    k = 0;
    while (fsm_state != 2'd1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("exec_state", {30'd0, fsm_state}, 32'd1);
    check("exec_alu_a", {16'd0, alu_a}, 32'h0000_ABCD);
    check("exec_alu_opcode", {29'd0, alu_opcode}, 32'd7);
    wait_idle();
    check("clr_out_data", {16'd0, out_data}, 32'd0);

    // Back-pressure: out_ready low, in_valid held with 8 commands.
    out_ready = 1'b0;
    accepted  = 0;
    in_valid  = 1'b1;
    for (int c = 0; c < 15; c++) begin
      in_load   = (accepted % 2 == 0);
      in_opcode = 3'(accepted % 6);
      in_data   = 16'(16'h0100 * accepted + 16'h0011);
      ok = in_ready && (accepted < 8);
      in_valid = (accepted < 8);
      @(posedge clk); #1;
      if (ok) accepted++;
    end
    in_valid = 1'b0;
    check("full_accepted", accepted, 32'd5);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_fifo_count", {29'd0, fifo_count}, 32'd4);
    out_ready = 1'b1;
    k = 0;
    while (fifo_count != 3'd3 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_count3", {29'd0, fifo_count}, 32'd3);
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    wait_idle();
    check("drain_empty", {29'd0, fifo_count}, 32'd0);
    check("drain_sb_empty", exp_q.size(), 32'd0);

    // Reset with a pending result and 3 queued commands.
    out_ready = 1'b0;
    push_cmd(1'b1, 3'd0, 16'h0005);
    push_cmd(1'b0, 3'd0, 16'h0000);
    push_cmd(1'b0, 3'd2, 16'h0000);
    push_cmd(1'b0, 3'd4, 16'h0000);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_fifo_count", {29'd0, fifo_count}, 32'd3);
    do_reset();
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_acc", {16'd0, acc}, 32'd0);
    check("mid_rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid) k++;
    end
    check("no_stale_result", k, 32'd0);
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
- Upstream issue stage for the 16-bit single-operand ALU.
- Buffers incoming commands in a small FIFO and holds the 16-bit accumulator.
- Issues one command at a time by driving the ALU operand and opcode from the accumulator and the command.
- Writes the ALU result, or a load value, back into the accumulator and presents it on a valid/ready output port.

Parameters:
- DATA_W, 16, operand, accumulator and result width; must equal ALU width.
- OPC_W, 3, ALU opcode width.
- DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept a command.
- in_load  in  1  1 = load in_data into accumulator; 0 = ALU op.
- in_opcode  in  OPC_W  ALU opcode (ignored when in_load=1).
- in_data  in  DATA_W  load value (ignored when in_load=0).
- alu_a  out  DATA_W  ALU operand; always equals acc.
- alu_opcode  out  OPC_W  opcode of the current or last issued command.
- alu_result  in  DATA_W  combinational ALU result, same cycle.
- out_valid  out  1  out_data holds a completed command result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  DATA_W  accumulator value after the command.
- acc  out  DATA_W  current accumulator.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at an edge):
  - acc=0, out_data=0, out_valid=0, alu_opcode=0, fifo_count=0, FSM=IDLE.
  - FIFO contents are discarded; in_ready=1 on the next cycle.
  - Reset overrides every other event, including mid-operation with out_valid=1.
- FIFO:
  - Entry is {load, opcode, data}.
  - Enqueue when in_valid && in_ready.
  - in_ready = (fifo_count < DEPTH), computed from the current count only. No enqueue-on-full even when a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
- FSM states IDLE, EXEC, WAIT_OUT:
  - IDLE: if fifo_count>0, pop the head into the command register (alu_opcode updates at this edge) and go to EXEC; else stay.
  - EXEC (exactly 1 cycle): the ALU sees alu_a=acc, alu_opcode=cmd opcode. At the edge, acc and out_data take in_data if load, else alu_result. Set out_valid=1 and go to WAIT_OUT.
  - WAIT_OUT: hold out_data and acc. When out_valid && out_ready, clear out_valid at the edge and go to IDLE.
  - Pops occur only in IDLE, so the maximum throughput is one command per 3 cycles.
- Latency: a command enqueued at edge N into an empty FIFO with FSM in IDLE is popped at N+1. out_valid rises at N+2.
- Arithmetic: performed entirely by the ALU. acc wraps modulo 2^DATA_W with no saturation; the sequencer adds no logic of its own.
- out_valid, once set, must not drop and out_data must not change until the handshake completes.
- busy = (state != IDLE) || (fifo_count != 0).

Test Plan:
- After reset, push {load, 0x1234} then {op 000} with out_ready=1.
  - Required: outputs 0x1234, then 0x1235; acc=0x1235.
  - Required: the first out_valid occurs 2 cycles after the enqueue edge.
- From acc=0x1235, push op 010, then op 101.
  - Required: 0xEDCA, then 0x76E5.
- Load 0xFFFF, then op 000.
  - Required: out_data=0x0000 (wrap-around), acc=0x0000.
- Hold out_ready=0 and drive in_valid=1 continuously with 8 commands.
  - Required: exactly 5 accepted (1 in execution, 4 in FIFO), then in_ready=0 and fifo_count=4.
  - Release out_ready: all 5 results drain in order, with in_ready returning as the FIFO empties.
- With out_valid=1 and 3 entries queued, assert rst_n=0 for one edge.
  - Required: out_valid=0, acc=0, fifo_count=0, busy=0, with no stale result afterwards.
- Push op 111 after a load of 0xABCD.
  - Required: out_data=0x0000.
  - Required: alu_a equals 0xABCD during the EXEC cycle.
